// File: rtl/modulo_pkg.sv
// modulo_pkg: state encoding and width helpers shared by the modulo/divider/reconstruct blocks. Rev 1.0
`default_nettype none

package modulo_pkg;

   localparam logic ST_IDLE    = 1'b0;
   localparam logic ST_CALC    = 1'b1;
   localparam int   ACC_FACTOR = 2;

   typedef enum logic {
      IDLE = ST_IDLE,
      CALC = ST_CALC
   } state_t;

   // Accumulator must hold a full SIZE x SIZE product plus a SIZE-bit addend.
   function automatic int acc_width(input int size);
      return ACC_FACTOR * size;
   endfunction

endpackage

`default_nettype wire

// File: rtl/modulo_reconstruct_sec_shift_add_step.sv
// shift_add_step: combinational next state of one radix-2 shift-add multiply step. Rev 1.0
`default_nettype none

module shift_add_step #(
   parameter int SIZE = 16,
   parameter int AW   = 2 * SIZE
) (
   input  logic [AW-1:0]   acc,
   input  logic [AW-1:0]   mcand,
   input  logic [SIZE-1:0] mplier,
   output logic [AW-1:0]   acc_nxt,
   output logic [AW-1:0]   mcand_nxt,
   output logic [SIZE-1:0] mplier_nxt
);

   always_comb begin
      acc_nxt    = mplier[0] ? (acc + mcand) : acc;
      mcand_nxt  = mcand << 1;
      mplier_nxt = mplier >> 1;
   end

endmodule

`default_nettype wire

// File: rtl/modulo_reconstruct_sec.sv
// modulo_reconstruct_sec: rebuilds divident = quotient*divisor + remainder with an early-terminating shift-add engine.
// Optional operand consistency check enabled by MODULO_RECONSTRUCT_CHECK_EN. Rev 1.0
`default_nettype none

module modulo_reconstruct_sec
   import modulo_pkg::*;
#(
   parameter int   SIZE            = 16,
   parameter logic CALCULATION_OUT = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [SIZE-1:0] quotient,
   input  logic [SIZE-1:0] divisor,
   input  logic [SIZE-1:0] remainder,
   input  logic            start,
   output logic            done,
   output logic [SIZE-1:0] divident,
   output logic            overflow,
   output logic            invalid
);

   localparam int AW = acc_width(SIZE);

   state_t            state;
   logic [AW-1:0]     acc;
   logic [AW-1:0]     mcand;
   logic [SIZE-1:0]   mplier;
   logic [AW-1:0]     acc_nxt;
   logic [AW-1:0]     mcand_nxt;
   logic [SIZE-1:0]   mplier_nxt;

   shift_add_step #(
      .SIZE (SIZE),
      .AW   (AW)
   ) u_step (
      .acc        (acc),
      .mcand      (mcand),
      .mplier     (mplier),
      .acc_nxt    (acc_nxt),
      .mcand_nxt  (mcand_nxt),
      .mplier_nxt (mplier_nxt)
   );

   // Terminates as soon as no multiplier bits remain, so latency tracks quotient magnitude.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= CALC;
                  acc    <= {{SIZE{1'b0}}, remainder};
                  mcand  <= {{SIZE{1'b0}}, divisor};
                  mplier <= quotient;
               end
            end
            CALC: begin
               if (mplier == '0) begin
                  state <= IDLE;
               end else begin
                  acc    <= acc_nxt;
                  mcand  <= mcand_nxt;
                  mplier <= mplier_nxt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign done     = (state == IDLE);
   assign divident = done ? acc[SIZE-1:0] : {SIZE{CALCULATION_OUT}};
   assign overflow = done & (|acc[AW-1:SIZE]);

`ifdef MODULO_RECONSTRUCT_CHECK_EN
   logic invalid_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         invalid_r <= 1'b0;
      end else if ((state == IDLE) && start) begin
         invalid_r <= (divisor == '0) | (remainder >= divisor);
      end
   end

   assign invalid = done & invalid_r;
`else
   assign invalid = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_modulo_reconstruct_sec.sv
// tb_modulo_reconstruct_sec: randomized scoreboard bench comparing against an arithmetic reference model.
`default_nettype none

module tb_modulo_reconstruct_sec;

   localparam int   SIZE = 16;
   localparam logic CO   = 1'b1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [SIZE-1:0] quotient, divisor, remainder;
   logic            start;
   logic            done, overflow, invalid;
   logic [SIZE-1:0] divident;

   modulo_reconstruct_sec #(
      .SIZE            (SIZE),
      .CALCULATION_OUT (CO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .quotient  (quotient),
      .divisor   (divisor),
      .remainder (remainder),
      .start     (start),
      .done      (done),
      .divident  (divident),
      .overflow  (overflow),
      .invalid   (invalid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] full;
      int          lat;
      logic        inv;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
   endtask

   function automatic exp_t model(input logic [SIZE-1:0] q, d, r);
      exp_t   e;
      longint f;
      int     k;
      f = longint'(q) * longint'(d) + longint'(r);
      e.full = f[31:0];
      k = 0;
      for (int i = 0; i < SIZE; i++) if (q[i]) k = i + 1;
      e.lat = k + 1;
`ifdef MODULO_RECONSTRUCT_CHECK_EN
      e.inv = (d == 0) || (r >= d);
`else
      e.inv = 1'b0;
`endif
      return e;
   endfunction

   // Monitor: checks busy outputs, pops on each done rise, checks result hold afterwards.
   logic            prev_done = 1'b1;
   int              busy = 0;
   logic [SIZE-1:0] last_div = '0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         busy     = 0;
         last_div = '0;
      end else if (!done) begin
         busy++;
         chk("busy_divident", divident, {SIZE{CO}});
         chk("busy_overflow", overflow, 0);
         chk("busy_invalid", invalid, 0);
      end else if (!prev_done) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("latency", busy, e.lat);
            chk("divident", divident, e.full[15:0]);
            chk("overflow", overflow, e.full[31:16] != 0);
            chk("invalid", invalid, e.inv);
            last_div = e.full[15:0];
         end
         busy = 0;
      end else begin
         chk("hold_divident", divident, last_div);
      end
      prev_done = done;
   end

   task automatic wait_idle(input bit noise);
      int n = 0;
      while (!done && n < 40) begin
         if (noise) begin
            start     = 1'($urandom);
            quotient  = SIZE'($urandom);
            divisor   = SIZE'($urandom);
            remainder = SIZE'($urandom);
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      if (n >= 40) chk("done_timeout", done, 1);
   endtask

   task automatic issue(input logic [SIZE-1:0] q, d, r, input bit noise);
      quotient  = q;
      divisor   = d;
      remainder = r;
      start     = 1'b1;
      sb.push_back(model(q, d, r));
      @(negedge clk);
      start = 1'b0;
      wait_idle(noise);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'($urandom);
      quotient  = SIZE'($urandom);
      divisor   = SIZE'($urandom);
      remainder = SIZE'($urandom);
      #2;
      chk("rst_done", done, 1);
      chk("rst_divident", divident, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_invalid", invalid, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      start = 1'b0;
      @(negedge clk);

      issue(16'd7, 16'd9, 16'd4, 1'b0);
      issue(16'd0, 16'd123, 16'd5, 1'b0);
      issue(16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0);
      issue(16'd2, 16'd5, 16'd5, 1'b0);
      issue(16'd3, 16'd0, 16'd0, 1'b0);
      issue(16'd4, 16'd5, 16'd4, 1'b0);

      // Start pulse with different operands mid-calculation must be ignored.
      quotient  = 16'h8000;
      divisor   = 16'd3;
      remainder = 16'd0;
      start     = 1'b1;
      sb.push_back(model(16'h8000, 16'd3, 16'd0));
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      quotient  = 16'h1234;
      divisor   = 16'h0055;
      remainder = 16'h0011;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [SIZE-1:0] q, d, r;
         q = SIZE'($urandom);
         d = SIZE'($urandom);
         r = SIZE'($urandom);
         if (($urandom % 4) == 0) q = q >> ($urandom % 16);
         if (($urandom % 4) == 0) r = (d == 0) ? 0 : r % d;
         issue(q, d, r, 1'b1);
         repeat ($urandom % 3) @(negedge clk);
      end

      // Asynchronous reset in the middle of a long calculation.
      quotient  = 16'h8000;
      divisor   = 16'd3;
      remainder = 16'd0;
      start     = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("abort_done", done, 1);
      chk("abort_divident", divident, 0);
      chk("abort_overflow", overflow, 0);
      chk("abort_invalid", invalid, 0);
      @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      chk("post_abort_done", done, 1);

      issue(16'd9, 16'd7, 16'd6, 1'b0);
      repeat (2) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
      $fatal(1);
   end

endmodule

`default_nettype wire
